buzzer_round_controller: RTL
============================

// Module: buzzer_round_controller
// PURPOSE
//  Quizmaster-side controller for the two-player buzzer. It arms a round,
//  synchronises the raw player buttons and latches the first press. It then
//  times the winner's answer, takes the judge's verdict and keeps the scores.
//  It drives the player lamps A/B and sits between the player buttons and the
//  board LEDs/7-seg score display.
// PARAMETERS
//  ANSWER_CYCLES  1000  clk cycles allowed for an answer after a win (>=2)
//  TIMER_W        16    answer-timer width; must hold ANSWER_CYCLES-1
//  SCORE_W        4     per-player score width; saturates at 2**SCORE_W-1
// PORTS
//  clk        in   1        single clock, all logic rising-edge
//  rst_n      in   1        asynchronous, active-low reset
//  start      in   1        pulse: arm a new round (honoured only in IDLE)
//  a          in   1        raw player-A button, asynchronous
//  b          in   1        raw player-B button, asynchronous
//  judge_ok   in   1        pulse: current answer correct
//  judge_bad  in   1        pulse: current answer wrong
//  armed      out  1        high while in ARMED
//  A          out  1        player-A lamp, high in ANSWER_A
//  B          out  1        player-B lamp, high in ANSWER_B
//  timeout    out  1        one-cycle pulse when the answer timer expires
//  round_done out  1        one-cycle pulse in DONE
//  score_a    out  SCORE_W  player-A score
//  score_b    out  SCORE_W  player-B score
// BEHAVIOUR
//  Reset (async): state=IDLE; every output 0; lockouts, tie bit and timer 0.
//  Reset mid-round aborts the round immediately; scores are lost.
//  Inputs:
//  - a/b pass a 2-flop synchroniser, then a rising-edge detector.
//  - A press held from before edge k raises the lamp on edge k+2.
//  - A button held down counts once; it must be released to press again.
//  States (one of IDLE, ARMED, ANSWER_A, ANSWER_B, DONE):
//  - IDLE: start -> ARMED; clear lock_a and lock_b.
//  - ARMED: edge_a & ~lock_a -> ANSWER_A. edge_b & ~lock_b -> ANSWER_B.
//  - Tie (both edges, both unlocked, same cycle): the winner is the player
//    the tie bit favours, and the tie bit then toggles. The tie bit resets to
//    favour A.
//  - ANSWER_x: on entry, timer=ANSWER_CYCLES-1; it decrements each cycle.
//    - judge_ok -> score_x+1, saturating -> DONE.
//    - judge_bad, or timer==0 with no verdict: set lock_x. If the other
//      player is unlocked -> ARMED, else -> DONE. Expiry also pulses timeout.
//    - judge_ok & judge_bad in the same cycle: both ignored.
//    - A verdict in the expiry cycle takes precedence over the timeout.
//  - DONE: round_done=1 for one cycle -> IDLE.
//  - start outside IDLE is ignored; judge pulses outside ANSWER_x are ignored.
//  - Presses outside ARMED are ignored, except as noted under CONFIGURATION.
//  - A and B are never high together.
// CONFIGURATION
//  BUZZER_FALSE_START_EN defined:
//  - A press edge in IDLE sets fs_x. The start that arms the round copies fs
//    into lock (false-start lockout), then clears fs.
//  - If both players false-started, start goes directly to DONE.
//  BUZZER_FALSE_START_EN undefined:
//  - Presses in IDLE are ignored; no fs registers are built.
// STRUCTURE
//  - Package buzzer_pkg: the state enum and the constants PLAYER_A=1'b0 and
//    PLAYER_B=1'b1.
//  - Sub-module buzzer_input_sync: a 2-flop synchroniser plus a rising-edge
//    pulse, instantiated once per button.
//  - FSM, timer, lockouts and scores live in the top module.
// TESTING
//  1. Reset, start, press a only -> A=1 two edges after the press; B=0;
//     judge_ok -> score_a=1, round_done pulse, back to IDLE.
//  2. a and b in the same cycle, twice in successive rounds -> A wins the
//     first round, B wins the second.
//  3. A wins; judge_bad -> lock_a, armed=1. Press a -> no effect. Press b ->
//     B=1; judge_bad -> DONE, scores unchanged.
//  4. ANSWER_CYCLES=8, A wins, no verdict -> timeout pulse 8 cycles after the
//     A rise; ARMED with A locked.
//  5. score_a preset to 15 by wins (SCORE_W=4), one more correct answer ->
//     stays 15. Verdict in the expiry cycle -> no timeout.
//  6. Assert rst_n low mid-ANSWER_B -> all outputs 0 asynchronously. With
//     BUZZER_FALSE_START_EN: press b in IDLE, then start -> b is ignored for
//     that round.

Source files
------------

// File: rtl/buzzer_pkg.sv
// buzzer_pkg
//   Shared definitions for the two-player buzzer round controller:
//   state encodings, player identifiers and the state type.
package buzzer_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_ARMED    = 3'd1;
  localparam state_t ST_ANSWER_A = 3'd2;
  localparam state_t ST_ANSWER_B = 3'd3;
  localparam state_t ST_DONE     = 3'd4;

  localparam logic PLAYER_A = 1'b0;
  localparam logic PLAYER_B = 1'b1;

endpackage

// File: rtl/buzzer_input_sync.sv
// buzzer_input_sync
//   Brings one raw, asynchronous player button into the clk domain through a
//   two-flop synchroniser and produces a single-cycle pulse on each
//   synchronised rising edge. A button held down yields exactly one pulse.
// Ports:
//   clk   in  1  rising-edge clock
//   rst_n in  1  asynchronous active-low reset
//   btn   in  1  raw button level
//   rise  out 1  one-cycle pulse on a synchronised 0->1 transition
module buzzer_input_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic rise
);

  logic sync1_r;
  logic sync2_r;
  logic prev_r;

  // Synchroniser chain plus the delayed copy used for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  // Decoded from registers only, so the FSM sees the press one edge after
  // the second synchroniser stage captures it.
  assign rise = sync2_r & ~prev_r;

endmodule

// File: rtl/buzzer_round_controller.sv
// buzzer_round_controller
//   Quizmaster-side controller for a two-player buzzer. Arms a round, latches
//   the first (synchronised) press, times the winner's answer, applies the
//   judge's verdict and keeps saturating per-player scores.
// Optional feature: define BUZZER_FALSE_START_EN to lock out, for the next
//   round, any player who presses while the controller is IDLE.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 arm a new round (IDLE only)
//   a, b                  raw player buttons
//   judge_ok, judge_bad   verdict pulses for the current answer
//   armed                 high while waiting for a press
//   A, B                  player lamps (never both high)
//   timeout               one-cycle pulse when the answer timer expires
//   round_done            one-cycle pulse when the round ends
//   score_a, score_b      saturating scores
module buzzer_round_controller
  import buzzer_pkg::*;
#(
  parameter int ANSWER_CYCLES = 1000,
  parameter int TIMER_W       = 16,
  parameter int SCORE_W       = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               a,
  input  logic               b,
  input  logic               judge_ok,
  input  logic               judge_bad,
  output logic               armed,
  output logic               A,
  output logic               B,
  output logic               timeout,
  output logic               round_done,
  output logic [SCORE_W-1:0] score_a,
  output logic [SCORE_W-1:0] score_b
);

  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(ANSWER_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
  localparam logic [TIMER_W-1:0] TIMER_ZERO = TIMER_W'(0);
  localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    if (s == SCORE_MAX) begin
      sat_inc = s;
    end else begin
      sat_inc = s + SCORE_ONE;
    end
  endfunction

  logic edge_a_s, edge_b_s;

  buzzer_input_sync u_sync_a (.clk(clk), .rst_n(rst_n), .btn(a), .rise(edge_a_s));
  buzzer_input_sync u_sync_b (.clk(clk), .rst_n(rst_n), .btn(b), .rise(edge_b_s));

  state_t             state_r, state_next_s;
  logic               lock_a_r, lock_a_next_s;
  logic               lock_b_r, lock_b_next_s;
  logic               tie_r, tie_next_s;
  logic [TIMER_W-1:0] timer_r, timer_next_s;
  logic [SCORE_W-1:0] score_a_r, score_a_next_s;
  logic [SCORE_W-1:0] score_b_r, score_b_next_s;
  logic               timeout_next_s;
  logic               win_s, winner_s, ok_s, bad_s, expire_s;
  logic               armed_r, lamp_a_r, lamp_b_r, timeout_r, done_r;
`ifdef BUZZER_FALSE_START_EN
  logic               fs_a_r, fs_a_next_s;
  logic               fs_b_r, fs_b_next_s;
`endif

  // Simultaneous verdicts cancel each other out.
  assign ok_s     = judge_ok & ~judge_bad;
  assign bad_s    = judge_bad & ~judge_ok;
  assign expire_s = (timer_r == TIMER_ZERO);

  // Next-state, lockout, tie, timer and score computation.
  always_comb begin
    state_next_s   = state_r;
    lock_a_next_s  = lock_a_r;
    lock_b_next_s  = lock_b_r;
    tie_next_s     = tie_r;
    timer_next_s   = timer_r;
    score_a_next_s = score_a_r;
    score_b_next_s = score_b_r;
    timeout_next_s = 1'b0;
    win_s          = 1'b0;
    winner_s       = PLAYER_A;
`ifdef BUZZER_FALSE_START_EN
    fs_a_next_s    = fs_a_r;
    fs_b_next_s    = fs_b_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (start) begin
`ifdef BUZZER_FALSE_START_EN
          // A press coinciding with start still counts as a false start.
          lock_a_next_s = fs_a_r | edge_a_s;
          lock_b_next_s = fs_b_r | edge_b_s;
          fs_a_next_s   = 1'b0;
          fs_b_next_s   = 1'b0;
          if ((fs_a_r | edge_a_s) && (fs_b_r | edge_b_s)) begin
            state_next_s = ST_DONE;
          end else begin
            state_next_s = ST_ARMED;
          end
`else
          lock_a_next_s = 1'b0;
          lock_b_next_s = 1'b0;
          state_next_s  = ST_ARMED;
`endif
        end else begin
`ifdef BUZZER_FALSE_START_EN
          fs_a_next_s = fs_a_r | edge_a_s;
          fs_b_next_s = fs_b_r | edge_b_s;
`endif
        end
      end
      ST_ARMED: begin
        if (edge_a_s && !lock_a_r && edge_b_s && !lock_b_r) begin
          // Tie: alternate the favoured player so neither wins every tie.
          win_s      = 1'b1;
          winner_s   = tie_r;
          tie_next_s = ~tie_r;
        end else if (edge_a_s && !lock_a_r) begin
          win_s    = 1'b1;
          winner_s = PLAYER_A;
        end else if (edge_b_s && !lock_b_r) begin
          win_s    = 1'b1;
          winner_s = PLAYER_B;
        end else begin
          win_s = 1'b0;
        end
        if (win_s) begin
          timer_next_s = TIMER_LOAD;
          state_next_s = (winner_s == PLAYER_A) ? ST_ANSWER_A : ST_ANSWER_B;
        end else begin
          state_next_s = ST_ARMED;
        end
      end
      ST_ANSWER_A: begin
        if (ok_s) begin
          score_a_next_s = sat_inc(score_a_r);
          state_next_s   = ST_DONE;
        end else if (bad_s || expire_s) begin
          lock_a_next_s  = 1'b1;
          timeout_next_s = ~bad_s;
          state_next_s   = lock_b_r ? ST_DONE : ST_ARMED;
        end else begin
          timer_next_s = timer_r - TIMER_ONE;
        end
      end
      ST_ANSWER_B: begin
        if (ok_s) begin
          score_b_next_s = sat_inc(score_b_r);
          state_next_s   = ST_DONE;
        end else if (bad_s || expire_s) begin
          lock_b_next_s  = 1'b1;
          timeout_next_s = ~bad_s;
          state_next_s   = lock_a_r ? ST_DONE : ST_ARMED;
        end else begin
          timer_next_s = timer_r - TIMER_ONE;
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State, bookkeeping and output registers; outputs decode the next state so
  // they are registered yet aligned with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      lock_a_r  <= 1'b0;
      lock_b_r  <= 1'b0;
      tie_r     <= PLAYER_A;
      timer_r   <= TIMER_ZERO;
      score_a_r <= {SCORE_W{1'b0}};
      score_b_r <= {SCORE_W{1'b0}};
      armed_r   <= 1'b0;
      lamp_a_r  <= 1'b0;
      lamp_b_r  <= 1'b0;
      timeout_r <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      lock_a_r  <= lock_a_next_s;
      lock_b_r  <= lock_b_next_s;
      tie_r     <= tie_next_s;
      timer_r   <= timer_next_s;
      score_a_r <= score_a_next_s;
      score_b_r <= score_b_next_s;
      armed_r   <= (state_next_s == ST_ARMED);
      lamp_a_r  <= (state_next_s == ST_ANSWER_A);
      lamp_b_r  <= (state_next_s == ST_ANSWER_B);
      timeout_r <= timeout_next_s;
      done_r    <= (state_next_s == ST_DONE);
    end
  end

`ifdef BUZZER_FALSE_START_EN
  // False-start flags collected while IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fs_a_r <= 1'b0;
      fs_b_r <= 1'b0;
    end else begin
      fs_a_r <= fs_a_next_s;
      fs_b_r <= fs_b_next_s;
    end
  end
`endif

  assign armed      = armed_r;
  assign A          = lamp_a_r;
  assign B          = lamp_b_r;
  assign timeout    = timeout_r;
  assign round_done = done_r;
  assign score_a    = score_a_r;
  assign score_b    = score_b_r;

endmodule
